hpi_target: RTL



---
 rtl/hpi_pkg.sv | 22 ++
 rtl/hpi_target_ram.sv | 23 ++
 rtl/hpi_target.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/hpi_pkg.sv
// Shared definitions for the HPI target: register selects, STATUS bit layout
// and the host-strobe FSM encoding.
package hpi_pkg;

    localparam logic [1:0] HPI_REG_DATA    = 2'b00;
    localparam logic [1:0] HPI_REG_MAILBOX = 2'b01;
    localparam logic [1:0] HPI_REG_ADDRESS = 2'b10;
    localparam logic [1:0] HPI_REG_STATUS  = 2'b11;

    localparam int STAT_MBX_OUT_FULL = 0;
    localparam int STAT_MBX_IN_FULL  = 1;
    localparam int STAT_MBX_IN_OVF   = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ACTIVE,
        S_WR_COMMIT,
        S_RD_ACTIVE,
        S_RD_DONE
    } hpi_state_e;

endpackage

// File: rtl/hpi_target_ram.sv
// Single-port word RAM: synchronous write, registered read-before-write output.
// The registered output is the target's DATA prefetch word.
module hpi_target_ram #(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [MEM_AW-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem [2**MEM_AW];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/hpi_target.sv
// HPI responder: 4-register host port backed by a word RAM plus a two-way mailbox.
// Define HPI_TARGET_AUTOINC_EN to post-step addr_reg by 2 on every DATA access.
module hpi_target
    import hpi_pkg::*;
#(
    parameter int MEM_AW  = 10,
    parameter int MIN_GAP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  hpi_address,
    inout  wire  [15:0] hpi_data,
    input  logic        hpi_oen,
    input  logic        hpi_wen,
    input  logic        hpi_csn,
    input  logic        hpi_resetn,
    output logic        hpi_irq,
    output logic [15:0] mbx_in_data,
    output logic        mbx_in_valid,
    input  logic        mbx_in_ack,
    input  logic [15:0] mbx_out_data,
    input  logic        mbx_out_wr
);

    // Hosts strobing faster than commit + prefetch latency are unsupported.
    if (MIN_GAP < 2) begin : g_min_gap_below_prefetch_latency
    end

    logic [1:0]       rstn_sync_q, oen_sync_q, wen_sync_q, csn_sync_q;
    logic [1:0][1:0]  addr_pipe_q;
    logic [1:0][15:0] data_pipe_q;

    hpi_state_e  state_q, state_d;
    logic [15:0] addr_reg_q, addr_reg_d;
    logic [15:0] mbx_out_q, mbx_out_d;
    logic        out_full_q, out_full_d;
    logic [15:0] in_data_q, in_data_d;
    logic        in_valid_q, in_valid_d;
    logic        in_ovf_q, in_ovf_d;
    logic [1:0]  cap_addr_q, cap_addr_d;
    logic [15:0] cap_data_q, cap_data_d;

    logic        oen_s, wen_s, csn_s, host_clr;
    logic        commit_wr, commit_rd, data_step, ram_we;
    logic [15:0] prefetch, status_word, rd_mux;
    logic        rd_drive;

    assign oen_s    = oen_sync_q[1];
    assign wen_s    = wen_sync_q[1];
    assign csn_s    = csn_sync_q[1];
    assign host_clr = ~rstn_sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstn_sync_q <= 2'b00;
            oen_sync_q  <= 2'b11;
            wen_sync_q  <= 2'b11;
            csn_sync_q  <= 2'b11;
            addr_pipe_q <= '0;
            data_pipe_q <= '0;
            state_q     <= S_IDLE;
            addr_reg_q  <= '0;
            mbx_out_q   <= '0;
            out_full_q  <= 1'b0;
            in_data_q   <= '0;
            in_valid_q  <= 1'b0;
            in_ovf_q    <= 1'b0;
            cap_addr_q  <= '0;
            cap_data_q  <= '0;
        end else begin
            rstn_sync_q <= {rstn_sync_q[0], hpi_resetn};
            oen_sync_q  <= {oen_sync_q[0], hpi_oen};
            wen_sync_q  <= {wen_sync_q[0], hpi_wen};
            csn_sync_q  <= {csn_sync_q[0], hpi_csn};
            addr_pipe_q <= {addr_pipe_q[0], hpi_address};
            data_pipe_q <= {data_pipe_q[0], hpi_data};
            state_q     <= state_d;
            addr_reg_q  <= addr_reg_d;
            mbx_out_q   <= mbx_out_d;
            out_full_q  <= out_full_d;
            in_data_q   <= in_data_d;
            in_valid_q  <= in_valid_d;
            in_ovf_q    <= in_ovf_d;
            cap_addr_q  <= cap_addr_d;
            cap_data_q  <= cap_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_reg_d = addr_reg_q;
        mbx_out_d  = mbx_out_q;
        out_full_d = out_full_q;
        in_data_d  = in_data_q;
        in_valid_d = in_valid_q;
        in_ovf_d   = in_ovf_q;
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        commit_wr  = 1'b0;
        commit_rd  = 1'b0;

        // Commits act on the address/data captured during the strobe-low
        // window, since the pipeline already holds post-edge values.
        unique case (state_q)
            S_IDLE: begin
                if (!csn_s && !wen_s) begin
                    state_d    = S_WR_ACTIVE;
                    cap_addr_d = addr_pipe_q[1];
                    cap_data_d = data_pipe_q[1];
                end else if (!csn_s && !oen_s) begin
                    state_d    = S_RD_ACTIVE;
                    cap_addr_d = addr_pipe_q[1];
                end
            end
            S_WR_ACTIVE: begin
                if (csn_s) begin
                    state_d = S_IDLE;
                end else if (!wen_s) begin
                    cap_addr_d = addr_pipe_q[1];
                    cap_data_d = data_pipe_q[1];
                end else begin
                    commit_wr = 1'b1;
                    state_d   = S_WR_COMMIT;
                end
            end
            S_RD_ACTIVE: begin
                if (csn_s) begin
                    state_d = S_IDLE;
                end else if (!wen_s) begin
                    state_d    = S_WR_ACTIVE;
                    cap_addr_d = addr_pipe_q[1];
                    cap_data_d = data_pipe_q[1];
                end else if (!oen_s) begin
                    cap_addr_d = addr_pipe_q[1];
                end else begin
                    commit_rd = 1'b1;
                    state_d   = S_RD_DONE;
                end
            end
            S_WR_COMMIT: state_d = S_IDLE;
            S_RD_DONE:   state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

`ifdef HPI_TARGET_AUTOINC_EN
        data_step = (commit_wr || commit_rd) && (cap_addr_q == HPI_REG_DATA);
`else
        data_step = 1'b0;
`endif

        if (commit_wr && cap_addr_q == HPI_REG_ADDRESS) addr_reg_d = cap_data_q;
        else if (data_step)                             addr_reg_d = addr_reg_q + 16'd2;

        // A local write landing on the host's clearing read keeps FULL set.
        if (mbx_out_wr) begin
            mbx_out_d  = mbx_out_data;
            out_full_d = 1'b1;
        end else if (commit_rd && cap_addr_q == HPI_REG_MAILBOX) begin
            out_full_d = 1'b0;
        end

        if (commit_wr && cap_addr_q == HPI_REG_MAILBOX) begin
            in_data_d  = cap_data_q;
            in_valid_d = 1'b1;
            if (in_valid_q && !mbx_in_ack) in_ovf_d = 1'b1;
        end else if (mbx_in_ack) begin
            in_valid_d = 1'b0;
        end

        if (commit_rd && cap_addr_q == HPI_REG_STATUS) in_ovf_d = 1'b0;

        if (host_clr) begin
            state_d    = S_IDLE;
            addr_reg_d = '0;
            mbx_out_d  = '0;
            out_full_d = 1'b0;
            in_data_d  = '0;
            in_valid_d = 1'b0;
            in_ovf_d   = 1'b0;
        end
    end

    assign ram_we = commit_wr && (cap_addr_q == HPI_REG_DATA) && !host_clr;

    hpi_target_ram #(.MEM_AW(MEM_AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_reg_q[MEM_AW:1]),
        .wdata (cap_data_q),
        .rdata (prefetch)
    );

    always_comb begin
        status_word                    = '0;
        status_word[STAT_MBX_OUT_FULL] = out_full_q;
        status_word[STAT_MBX_IN_FULL]  = in_valid_q;
        status_word[STAT_MBX_IN_OVF]   = in_ovf_q;
    end

    always_comb begin
        rd_mux = prefetch;
        unique case (hpi_address)
            HPI_REG_DATA:    rd_mux = prefetch;
            HPI_REG_MAILBOX: rd_mux = mbx_out_q;
            HPI_REG_ADDRESS: rd_mux = addr_reg_q;
            HPI_REG_STATUS:  rd_mux = status_word;
            default:         rd_mux = prefetch;
        endcase
    end

    // Raw pins gate the drive so reads are zero-latency; a write strobe wins.
    assign rd_drive = !reset && !hpi_csn && !hpi_oen && hpi_wen;
    assign hpi_data = rd_drive ? rd_mux : {16{1'bz}};

    assign hpi_irq      = out_full_q;
    assign mbx_in_data  = in_data_q;
    assign mbx_in_valid = in_valid_q;

endmodule
